// File: rtl/budget_window_controller_if.sv
// Configuration and arbiter-grant bus of the budget window controller.
interface budget_window_controller_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int PERIOD_SIZE      = 16
);
  logic                                  cfg_write;
  logic [$clog2(NUMBER_OF_QUEUES+1)-1:0] cfg_addr;
  logic [PERIOD_SIZE-1:0]                cfg_data;
  logic                                  grant_valid;
  logic [$clog2(NUMBER_OF_QUEUES)-1:0]   grant_queue;
  logic [NUMBER_OF_QUEUES-1:0]           throttle;

  modport master (
    output cfg_write, cfg_addr, cfg_data, grant_valid, grant_queue,
    input  throttle
  );

  modport slave (
    input  cfg_write, cfg_addr, cfg_data, grant_valid, grant_queue,
    output throttle
  );
endinterface

// File: rtl/budget_window_controller.sv
// Per-queue bandwidth regulation: counts grants per window and throttles
// queues whose budget is exhausted; budgets/period replenish at each window.
module budget_window_controller #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 8,
  parameter int PERIOD_SIZE      = 16,
  parameter int DEFAULT_PERIOD   = 1000
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  enable,
  budget_window_controller_if.slave             bus,
  output logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] consumed,
  output logic                                  period_start,
  output logic [15:0]                           window_count
);
  localparam int QW = $clog2(NUMBER_OF_QUEUES);
  localparam int AW = $clog2(NUMBER_OF_QUEUES+1);

  typedef enum logic [1:0] {IDLE, REPLENISH, RUN} state_t;

  state_t                   state, state_next;
  logic [PERIOD_SIZE-1:0]   timer;
  logic [PERIOD_SIZE-1:0]   shadow_period, active_period, period_last;
  logic [REGISTER_SIZE-1:0] shadow_budget [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] active_budget [NUMBER_OF_QUEUES];
  logic [REGISTER_SIZE-1:0] count         [NUMBER_OF_QUEUES];
  logic [NUMBER_OF_QUEUES-1:0] grant_hit;

  // Last timer value of a window; a zero period behaves as a period of one.
  always_comb begin
    period_last = '0;
    if (active_period != '0) period_last = active_period - PERIOD_SIZE'(1);
  end

  // Next-state logic and the window-start pulse.
  always_comb begin
    state_next   = state;
    period_start = (state == REPLENISH);
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      state_next = REPLENISH;
        REPLENISH: state_next = RUN;
        RUN:       if (timer == period_last) state_next = REPLENISH;
        default:   state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Decode the grant into a one-hot hit vector; out-of-range queues match nothing.
  always_comb begin
    grant_hit = '0;
    for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++)
      grant_hit[q] = bus.grant_valid && (bus.grant_queue == QW'(q));
  end

  // Shadow configuration registers, written at any time.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_period <= PERIOD_SIZE'(DEFAULT_PERIOD);
      for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++) shadow_budget[q] <= '0;
    end else if (bus.cfg_write) begin
      if (bus.cfg_addr == AW'(NUMBER_OF_QUEUES)) begin
        shadow_period <= bus.cfg_data;
      end else begin
        for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++)
          if (bus.cfg_addr == AW'(q)) shadow_budget[q] <= bus.cfg_data[REGISTER_SIZE-1:0];
      end
    end
  end

  // Window timer, window counter and the shadow-to-active copy at replenish.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer         <= '0;
      window_count  <= '0;
      active_period <= PERIOD_SIZE'(DEFAULT_PERIOD);
      for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++) active_budget[q] <= '0;
    end else if (enable) begin
      if (state == REPLENISH) begin
        timer         <= '0;
        window_count  <= window_count + 16'd1;
        active_period <= shadow_period;
        for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++) active_budget[q] <= shadow_budget[q];
      end else if (state == RUN) begin
        timer <= timer + PERIOD_SIZE'(1);
      end
    end
  end

  // Per-queue consumption; a replenish-cycle grant seeds the new window with 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++) count[q] <= '0;
    end else if (enable) begin
      if (state == REPLENISH) begin
        for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++)
          count[q] <= grant_hit[q] ? REGISTER_SIZE'(1) : '0;
      end else if (state == RUN) begin
        for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++)
          if (grant_hit[q] && (count[q] != '1)) count[q] <= count[q] + REGISTER_SIZE'(1);
      end
    end
  end

  // Throttle from registered state; a zero budget is unregulated.
  always_comb begin
    bus.throttle = '0;
    consumed     = '0;
    for (int unsigned q = 0; q < NUMBER_OF_QUEUES; q++) begin
      bus.throttle[q] = (state != IDLE) && (active_budget[q] != '0) &&
                        (count[q] >= active_budget[q]);
      consumed[q*REGISTER_SIZE +: REGISTER_SIZE] = count[q];
    end
  end
endmodule
